uart_rx: RTL
============

Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the UART transmitter.
- Samples the asynchronous serial input `input_rx` and recovers each byte at mid-bit.
- Presents each received byte on `data_byte` with a one-cycle `data_valid` strobe, or a one-cycle `frame_error` strobe on a bad stop bit.
- Uses the same baud/clock parameterisation as the transmitter, so a loopback of TX to RX works at defaults.

Parameters:
- CLK_FREQ, 10000000, system clock frequency in Hz.
- BAUDRATE, 115200, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUDRATE (86 at defaults), clocks per bit period; integer division.
- HALF_BIT, CLKS_PER_BIT/2 (43 at defaults), clocks from start-edge detection to mid-start-bit sample.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- input_rx  input  1  serial line, asynchronous to clk, idle high.
- data_byte  output  8  last correctly received byte, LSB first on the wire.
- data_valid  output  1  one-cycle strobe: data_byte was updated this cycle.
- frame_error  output  1  one-cycle strobe: the stop bit sampled low.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, data_byte=8'h00, data_valid=0, frame_error=0, busy=0, both synchronizer flops=1, clk_count=0, bit_index=0, shift register=0.
- Reset asserted mid-frame aborts the frame immediately; no strobe is issued.
- Synchronizer: 2-flop chain input_rx -> rx_meta -> rx_sync. The FSM uses only rx_sync.
- Counter: clk_count is 16 bits, compared against CLKS_PER_BIT-1 or HALF_BIT-1. bit_index is 3 bits, values 0..7.
- IDLE:
  - rx_sync==1: stay.
  - rx_sync==0: clk_count<=0, go to START.
- START:
  - Increment clk_count until clk_count==HALF_BIT-1, then sample rx_sync.
  - rx_sync==0: valid start; clk_count<=0, bit_index<=0, go to DATA.
  - rx_sync==1: glitch; return to IDLE with no strobe.
- DATA:
  - Increment clk_count until clk_count==CLKS_PER_BIT-1 (mid-bit).
  - At mid-bit: shift register[bit_index]<=rx_sync, clk_count<=0.
  - bit_index<7: bit_index++.
  - bit_index==7: bit_index<=0, go to STOP.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample rx_sync.
  - rx_sync==1: data_byte<=shift register, data_valid<=1 for exactly one cycle, go to IDLE.
  - rx_sync==0: frame_error<=1 for one cycle, data_byte unchanged, go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rx_sync==1, then go to IDLE. A held-low break line yields exactly one frame_error.
- Back-to-back frames: returning to IDLE at mid-stop-bit allows a start edge that immediately follows a stop bit to be caught. No idle gap is required.
- Strobe exclusivity: data_valid and frame_error are never high in the same cycle. Both are registered, driven 0 in all other cycles.
- data_byte persistence: holds its value until the next valid frame.
- busy: combinational or registered, but must be 1 in START, DATA, STOP and WAIT_IDLE, and 0 in IDLE.
- Latency: data_valid rises 3 + HALF_BIT + 9*CLKS_PER_BIT clocks (±1) after the input_rx falling start edge. At defaults this is 820±1.
- Tolerance: sampling at mid-bit tolerates ±40% bit-period skew accumulated over a frame.

Test Plan:
- Reset release with input_rx=1, idle 2000 clocks -> all outputs stay at reset values, busy=0.
- Serialize 8'h41 at 86 clk/bit (start 0, bits 1,0,0,0,0,0,1,0, stop 1) -> exactly one data_valid pulse; data_byte=8'h41 at the 820±1 cycle mark; frame_error never high.
- Two back-to-back frames 8'hA5 then 8'h3C with no idle gap -> two data_valid pulses about 860 clocks apart; data_byte=8'hA5 then 8'h3C.
- Low glitch of 20 clocks on an idle line -> FSM returns to IDLE at the mid-start sample, no strobes, busy high for at most 46 clocks.
- Frame 8'hFF with stop bit forced 0, line held low 2000 clocks, then released -> one frame_error pulse, data_byte keeps its prior value, busy stays 1 until 2 clocks after the line rises.
- rst_n pulled low for 5 clocks during bit 4 of 8'h55, then the next frame 8'h96 is sent after 1000 idle clocks -> no strobe for the aborted frame; 8'h96 is received with data_valid.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side bundle for the 8N1 UART receiver: the serial line in, the recovered byte and strobes out.
// The receiver takes the slave view; the serial source and byte consumer take the master view.
interface uart_rx_if;
    logic       input_rx;
    logic [7:0] data_byte;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    modport master (
        output input_rx,
        input  data_byte,
        input  data_valid,
        input  frame_error,
        input  busy
    );

    modport slave (
        input  input_rx,
        output data_byte,
        output data_valid,
        output frame_error,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the serial line, samples every bit at its middle and
// reports each frame as a one-cycle data_valid (good stop bit) or frame_error (bad stop bit).
module uart_rx #(
    parameter int CLK_FREQ     = 10_000_000,
    parameter int BAUDRATE     = 115_200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUDRATE,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave rx
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] clk_count;
    logic [15:0] clk_count_next;
    logic [2:0]  bit_index;
    logic [2:0]  bit_index_next;
    logic [7:0]  shift_reg;
    logic [7:0]  shift_reg_next;
    logic [7:0]  data_byte;
    logic [7:0]  data_byte_next;
    logic        data_valid;
    logic        data_valid_next;
    logic        frame_error;
    logic        frame_error_next;
    logic        rx_meta;
    logic        rx_sync;

    // Two-flop synchronizer; resets to the idle-high line level so reset never fakes a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx.input_rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            clk_count   <= 16'd0;
            bit_index   <= 3'd0;
            shift_reg   <= 8'h00;
            data_byte   <= 8'h00;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_next;
            clk_count   <= clk_count_next;
            bit_index   <= bit_index_next;
            shift_reg   <= shift_reg_next;
            data_byte   <= data_byte_next;
            data_valid  <= data_valid_next;
            frame_error <= frame_error_next;
        end
    end

    always_comb begin
        state_next       = state;
        clk_count_next   = clk_count;
        bit_index_next   = bit_index;
        shift_reg_next   = shift_reg;
        data_byte_next   = data_byte;
        data_valid_next  = 1'b0;
        frame_error_next = 1'b0;

        unique case (state)
            IDLE: begin
                if (!rx_sync) begin
                    clk_count_next = 16'd0;
                    state_next     = START;
                end
            end

            // A start bit that is no longer low at its middle was a glitch.
            START: begin
                if (clk_count == HALF_LAST) begin
                    if (!rx_sync) begin
                        clk_count_next = 16'd0;
                        bit_index_next = 3'd0;
                        state_next     = DATA;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    clk_count_next = clk_count + 16'd1;
                end
            end

            DATA: begin
                if (clk_count == BIT_LAST) begin
                    clk_count_next            = 16'd0;
                    shift_reg_next[bit_index] = rx_sync;
                    if (bit_index == 3'd7) begin
                        bit_index_next = 3'd0;
                        state_next     = STOP;
                    end else begin
                        bit_index_next = bit_index + 3'd1;
                    end
                end else begin
                    clk_count_next = clk_count + 16'd1;
                end
            end

            // Leaving at mid-stop-bit leaves half a bit to catch an immediately following start edge.
            STOP: begin
                if (clk_count == BIT_LAST) begin
                    clk_count_next = 16'd0;
                    if (rx_sync) begin
                        data_byte_next  = shift_reg;
                        data_valid_next = 1'b1;
                        state_next      = IDLE;
                    end else begin
                        frame_error_next = 1'b1;
                        state_next       = WAIT_IDLE;
                    end
                end else begin
                    clk_count_next = clk_count + 16'd1;
                end
            end

            WAIT_IDLE: begin
                if (rx_sync) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rx.data_byte   = data_byte;
    assign rx.data_valid  = data_valid;
    assign rx.frame_error = frame_error;
    assign rx.busy        = (state != IDLE);

endmodule
